// File: rtl/imem_loader.sv
// Boot loader for the single-cycle processor: receives a length-prefixed, checksummed
// byte stream, writes it into instruction memory word by word, then releases the CPU.
module imem_loader #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int NUM_WORDS = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    input  logic              load_req,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              error,
    output logic [31:0]       run_cycles
);

    localparam int BPW    = DATA_W / 8;
    localparam int BIDX_W = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BIDX_W-1:0] LAST_BYTE   = BIDX_W'(BPW - 1);
    localparam logic [16:0]       MAX_WORDS_L = 17'(NUM_WORDS);

    typedef enum logic [2:0] {
        S_LEN_LO,
        S_LEN_HI,
        S_DATA,
        S_CHK,
        S_RUN,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         len_q, len_d;
    logic [15:0]         word_idx_q, word_idx_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic [7:0]          csum_q, csum_d;
    logic [DATA_W-1:0]   word_buf_q, word_buf_d;
    logic                imem_we_q, imem_we_d;
    logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
    logic [DATA_W-1:0]   imem_wdata_q, imem_wdata_d;
    logic [31:0]         run_cycles_q, run_cycles_d;

    logic                xfer;
    logic [15:0]         len_full;
    logic                word_last;
    logic [DATA_W-1:0]   word_merged;

    // Incoming byte lands in the lane selected by the byte index (little-endian).
    generate
        for (genvar gi = 0; gi < BPW; gi++) begin : g_lane
            assign word_merged[gi*8 +: 8] =
                (byte_idx_q == BIDX_W'(gi)) ? in_byte : word_buf_q[gi*8 +: 8];
        end
    endgenerate

    assign xfer      = in_valid & in_ready;
    assign len_full  = {in_byte, len_q[7:0]};
    assign word_last = (word_idx_q == (len_q - 16'd1));

    always_comb begin
        state_d      = state_q;
        len_d        = len_q;
        word_idx_d   = word_idx_q;
        byte_idx_d   = byte_idx_q;
        csum_d       = csum_q;
        word_buf_d   = word_buf_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        run_cycles_d = run_cycles_q;
        in_ready     = 1'b0;

        case (state_q)
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (xfer) begin
                    len_d[7:0] = in_byte;
                    csum_d     = csum_q ^ in_byte;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (xfer) begin
                    len_d  = len_full;
                    csum_d = csum_q ^ in_byte;
                    if ({1'b0, len_full} > MAX_WORDS_L) begin
                        state_d = S_ERR;
                    end else if (len_full == 16'd0) begin
                        state_d = S_CHK;
                    end else begin
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (xfer) begin
                    csum_d     = csum_q ^ in_byte;
                    word_buf_d = word_merged;
                    if (byte_idx_q == LAST_BYTE) begin
                        byte_idx_d   = '0;
                        imem_we_d    = 1'b1;
                        imem_addr_d  = word_idx_q[ADDR_W-1:0];
                        imem_wdata_d = word_merged;
                        word_idx_d   = word_idx_q + 16'd1;
                        if (word_last) begin
                            state_d = S_CHK;
                        end
                    end else begin
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                    end
                end
            end
            S_CHK: begin
                in_ready = 1'b1;
                if (xfer) begin
                    state_d = (in_byte == csum_q) ? S_RUN : S_ERR;
                end
            end
            S_RUN: begin
                if (run_cycles_q != 32'hFFFF_FFFF) begin
                    run_cycles_d = run_cycles_q + 32'd1;
                end
            end
            default: begin
            end
        endcase

        // Restart wipes everything the previous load accumulated; memory address/data just hold.
        if ((state_q == S_RUN || state_q == S_ERR) && load_req) begin
            state_d      = S_LEN_LO;
            len_d        = '0;
            word_idx_d   = '0;
            byte_idx_d   = '0;
            csum_d       = '0;
            word_buf_d   = '0;
            run_cycles_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_LEN_LO;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_idx_q   <= '0;
            csum_q       <= '0;
            word_buf_q   <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            run_cycles_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            word_idx_q   <= word_idx_d;
            byte_idx_q   <= byte_idx_d;
            csum_q       <= csum_d;
            word_buf_q   <= word_buf_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            run_cycles_q <= run_cycles_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign run_cycles = run_cycles_q;
    assign cpu_rst    = (state_q == S_RUN);
    assign done       = (state_q == S_RUN);
    assign error      = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: loads good/bad/oversized/empty images, checks writes,
// release, run-cycle counting, restart via load_req and asynchronous reset mid-load.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        load_req;
    logic        imem_we;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;
    logic [31:0] run_cycles;

    int tests_run;
    int tests_failed;
    int base;

    logic [7:0]  wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    imem_loader #(.DATA_W(32), .ADDR_W(8), .NUM_WORDS(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .load_req   (load_req),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error),
        .run_cycles (run_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record every write strobe seen between edges.
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_wdata);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        if (gaps) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        in_valid = 1'b1;
        in_byte  = b;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        $display("[TB] byte %h sent", b);
    endtask

    task automatic pulse_load_req();
        load_req = 1'b1;
        @(negedge clk);
        load_req = 1'b0;
    endtask

    // N=2, words 11223344 and AABBCCDD; correct checksum is 02^00^44^33^22^11^DD^CC^BB^AA = 46.
    task automatic send_case1(input logic [7:0] csum, input bit gaps, input bit poke);
        logic [7:0] img [10];
        img = '{8'h02, 8'h00, 8'h44, 8'h33, 8'h22, 8'h11, 8'hDD, 8'hCC, 8'hBB, 8'hAA};
        for (int i = 0; i < 10; i++) begin
            send_byte(img[i], gaps);
            if (poke && i == 4) pulse_load_req();
        end
        send_byte(csum, gaps);
    endtask

    task automatic check_case1_writes(input string tag);
        check({tag, "_nwr"}, 32'(wr_addr_q.size() - base), 32'd2);
        if (wr_addr_q.size() - base == 2) begin
            check({tag, "_addr0"}, 32'(wr_addr_q[base]), 32'd0);
            check({tag, "_data0"}, wr_data_q[base], 32'h1122_3344);
            check({tag, "_addr1"}, 32'(wr_addr_q[base + 1]), 32'd1);
            check({tag, "_data1"}, wr_data_q[base + 1], 32'hAABB_CCDD);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;
        load_req = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cpu_rst", 32'(cpu_rst), 32'd0);
        check("rst_we", 32'(imem_we), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_wdata", imem_wdata, 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_run_cycles", run_cycles, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("idle_ready", 32'(in_ready), 32'd1);

        // Case 1: good image
        base = wr_addr_q.size();
        send_case1(8'h46, 1'b0, 1'b0);
        check("c1_done", 32'(done), 32'd1);
        check("c1_cpu_rst", 32'(cpu_rst), 32'd1);
        check("c1_error", 32'(error), 32'd0);
        check("c1_ready", 32'(in_ready), 32'd0);
        check("c1_run0", run_cycles, 32'd0);
        check_case1_writes("c1");
        $display("[TB] case1 done=%b cpu_rst=%b", done, cpu_rst);

        // Restart from RUN
        repeat (3) @(negedge clk);
        pulse_load_req();
        check("lr_cpu_rst", 32'(cpu_rst), 32'd0);
        check("lr_run_cycles", run_cycles, 32'd0);
        check("lr_done", 32'(done), 32'd0);
        check("lr_ready", 32'(in_ready), 32'd1);

        // Case 2: bad checksum
        base = wr_addr_q.size();
        send_case1(8'h47, 1'b0, 1'b0);
        check("c2_error", 32'(error), 32'd1);
        check("c2_cpu_rst", 32'(cpu_rst), 32'd0);
        check("c2_ready", 32'(in_ready), 32'd0);
        check("c2_done", 32'(done), 32'd0);
        $display("[TB] case2 error=%b", error);
        pulse_load_req();
        check("c2_cleared", 32'(error), 32'd0);

        // Case 3: N = 257
        base = wr_addr_q.size();
        send_byte(8'h01, 1'b0);
        send_byte(8'h01, 1'b0);
        check("c3_error", 32'(error), 32'd1);
        check("c3_ready", 32'(in_ready), 32'd0);
        repeat (4) @(negedge clk);
        check("c3_nwr", 32'(wr_addr_q.size() - base), 32'd0);
        $display("[TB] case3 error=%b", error);
        pulse_load_req();

        // Case 4: N = 0, checksum 00
        base = wr_addr_q.size();
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h00, 1'b0);
        check("c4_done", 32'(done), 32'd1);
        check("c4_cpu_rst", 32'(cpu_rst), 32'd1);
        check("c4_nwr", 32'(wr_addr_q.size() - base), 32'd0);
        $display("[TB] case4 done=%b", done);
        pulse_load_req();

        // Case 5: gaps plus an ignored load_req mid-DATA, then 10 cycles in RUN
        base = wr_addr_q.size();
        send_case1(8'h46, 1'b1, 1'b1);
        check("c5_done", 32'(done), 32'd1);
        check_case1_writes("c5");
        repeat (10) @(negedge clk);
        check("c5_run_cycles", run_cycles, 32'd10);
        $display("[TB] case5 run_cycles=%0d", run_cycles);
        pulse_load_req();

        // Case 6: async reset mid-DATA, then a clean reload
        send_byte(8'h02, 1'b0);
        send_byte(8'h00, 1'b0);
        send_byte(8'h44, 1'b0);
        send_byte(8'h33, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("c6_addr", 32'(imem_addr), 32'd0);
        check("c6_wdata", imem_wdata, 32'd0);
        check("c6_we", 32'(imem_we), 32'd0);
        check("c6_cpu_rst", 32'(cpu_rst), 32'd0);
        check("c6_error", 32'(error), 32'd0);
        check("c6_run_cycles", run_cycles, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        base = wr_addr_q.size();
        send_case1(8'h46, 1'b0, 1'b0);
        check("c6_done", 32'(done), 32'd1);
        check_case1_writes("c6");
        $display("[TB] case6 reload done=%b", done);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
